// File: rtl/host_csr_arbiter.sv
// Shares the host CSR port between an internal tohost poller and an external
// requester; one transaction outstanding, round-robin on ties, sticky pass/fail.
module host_csr_arbiter #(
  parameter int          POLL_INTERVAL = 16,
  parameter logic [11:0] TOHOST_ADDR   = 12'h780,
  parameter int          XLEN          = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ext_req_valid,
  output logic            ext_req_ready,
  input  logic            ext_req_rw,
  input  logic [11:0]     ext_req_addr,
  input  logic [XLEN-1:0] ext_req_data,
  output logic            ext_resp_valid,
  output logic [XLEN-1:0] ext_resp_data,
  output logic            csr_req_valid,
  input  logic            csr_req_ready,
  output logic            csr_req_rw,
  output logic [11:0]     csr_req_addr,
  output logic [XLEN-1:0] csr_req_data,
  input  logic            csr_resp_valid,
  output logic            csr_resp_ready,
  input  logic [XLEN-1:0] csr_resp_data,
  output logic            test_done,
  output logic            test_fail,
  output logic [XLEN-2:0] fail_code
);

  localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(POLL_INTERVAL - 1);
  localparam logic OWN_EXT  = 1'b0;
  localparam logic OWN_POLL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              poll_pending_q, poll_pending_d;
  logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic              req_rw_q, req_rw_d;
  logic [11:0]       req_addr_q, req_addr_d;
  logic [XLEN-1:0]   req_data_q, req_data_d;
  logic              ext_resp_valid_q, ext_resp_valid_d;
  logic [XLEN-1:0]   ext_resp_data_q, ext_resp_data_d;
  logic              test_done_q, test_done_d;
  logic              test_fail_q, test_fail_d;
  logic [XLEN-2:0]   fail_code_q, fail_code_d;

  logic grant_ext;
  logic grant_poll;
  logic poll_run;
  logic resp_is_one;
  logic resp_is_big;

  always_comb begin
    grant_ext  = 1'b0;
    grant_poll = 1'b0;
    if (state_q == ST_IDLE) begin
      if (ext_req_valid && poll_pending_q) begin
        grant_poll = (last_owner_q == OWN_EXT);
        grant_ext  = (last_owner_q == OWN_POLL);
      end else begin
        grant_ext  = ext_req_valid;
        grant_poll = poll_pending_q;
      end
    end
  end

  assign resp_is_big = |csr_resp_data[XLEN-1:1];
  assign resp_is_one = csr_resp_data[0] && !resp_is_big;

  // The timer only counts idle cycles, so polls are spaced by POLL_INTERVAL
  // idle cycles plus the transaction itself.
  assign poll_run = (state_q == ST_IDLE) && !poll_pending_q && !test_done_q && !test_fail_q;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_owner_d     = last_owner_q;
    poll_pending_d   = poll_pending_q;
    poll_cnt_d       = poll_cnt_q;
    req_rw_d         = req_rw_q;
    req_addr_d       = req_addr_q;
    req_data_d       = req_data_q;
    ext_resp_valid_d = 1'b0;
    ext_resp_data_d  = ext_resp_data_q;
    test_done_d      = test_done_q;
    test_fail_d      = test_fail_q;
    fail_code_d      = fail_code_q;

    if (poll_run) begin
      if (poll_cnt_q == '0) begin
        poll_pending_d = 1'b1;
        poll_cnt_d     = CNT_RELOAD;
      end else begin
        poll_cnt_d = poll_cnt_q - CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_ext) begin
          req_rw_d     = ext_req_rw;
          req_addr_d   = ext_req_addr;
          req_data_d   = ext_req_data;
          owner_d      = OWN_EXT;
          last_owner_d = OWN_EXT;
          state_d      = ST_REQ;
        end else if (grant_poll) begin
          req_rw_d       = 1'b0;
          req_addr_d     = TOHOST_ADDR;
          req_data_d     = '0;
          poll_pending_d = 1'b0;
          owner_d        = OWN_POLL;
          last_owner_d   = OWN_POLL;
          state_d        = ST_REQ;
        end
      end
      ST_REQ: begin
        if (csr_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (csr_resp_valid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_EXT) begin
            ext_resp_valid_d = 1'b1;
            ext_resp_data_d  = csr_resp_data;
          end else if (!test_done_q && !test_fail_q) begin
            // Zero means the test is still running; leave status untouched.
            if (resp_is_one) begin
              test_done_d = 1'b1;
            end else if (resp_is_big) begin
              test_fail_d = 1'b1;
              fail_code_d = csr_resp_data[XLEN-1:1];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      owner_q          <= OWN_EXT;
      last_owner_q     <= OWN_EXT;
      poll_pending_q   <= 1'b0;
      poll_cnt_q       <= CNT_RELOAD;
      req_rw_q         <= 1'b0;
      req_addr_q       <= '0;
      req_data_q       <= '0;
      ext_resp_valid_q <= 1'b0;
      ext_resp_data_q  <= '0;
      test_done_q      <= 1'b0;
      test_fail_q      <= 1'b0;
      fail_code_q      <= '0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_owner_q     <= last_owner_d;
      poll_pending_q   <= poll_pending_d;
      poll_cnt_q       <= poll_cnt_d;
      req_rw_q         <= req_rw_d;
      req_addr_q       <= req_addr_d;
      req_data_q       <= req_data_d;
      ext_resp_valid_q <= ext_resp_valid_d;
      ext_resp_data_q  <= ext_resp_data_d;
      test_done_q      <= test_done_d;
      test_fail_q      <= test_fail_d;
      fail_code_q      <= fail_code_d;
    end
  end

  // Handshake is suppressed while reset is asserted so nothing is lost.
  assign ext_req_ready  = grant_ext && reset_n;
  assign ext_resp_valid = ext_resp_valid_q;
  assign ext_resp_data  = ext_resp_data_q;
  assign csr_req_valid  = (state_q == ST_REQ);
  assign csr_req_rw     = req_rw_q;
  assign csr_req_addr   = req_addr_q;
  assign csr_req_data   = req_data_q;
  assign csr_resp_ready = (state_q == ST_RESP);
  assign test_done      = test_done_q;
  assign test_fail      = test_fail_q;
  assign fail_code      = fail_code_q;

endmodule
